// File: rtl/dac_output_stage.sv
// Output stage: range reduction, gain, offset, saturation and offset-binary conversion,
// followed by a serialiser that drives an SPI DAC with chip-select and LDAC strobes.
module dac_output_stage #(
    parameter int DAC_BITS     = 16,
    parameter int CLK_DIV      = 2,
    parameter int SAMPLE_SHIFT = 14
) (
    input  logic        Fg_clk,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic [31:0] sample_in,
    input  logic [15:0] Gain,
    input  logic [15:0] Offset,
    input  logic        Mute,
    input  logic        clr_flags,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_csn,
    output logic        dac_ldacn,
    output logic        busy,
    output logic        overrun,
    output logic        clip
);

    localparam int PW        = 49;
    localparam int ZW        = 50;
    localparam int GAIN_FRAC = 15;
    localparam int DW        = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
    localparam int BW        = $clog2(DAC_BITS + 1);

    localparam logic signed [ZW-1:0] Z_HALF   = ZW'(64'sd1 <<< (DAC_BITS - 1));
    localparam logic signed [ZW-1:0] Z_MAX    = Z_HALF - 50'sd1;
    localparam logic signed [ZW-1:0] Z_MIN    = -Z_HALF;
    localparam logic [DW-1:0]        DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]        DIV_INC  = DW'(1);
    localparam logic [BW-1:0]        BIT_LAST = BW'(DAC_BITS - 1);
    localparam logic [BW-1:0]        BIT_INC  = BW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CSH   = 2'd2,
        ST_LDAC  = 2'd3
    } state_t;

    logic signed [31:0]    sample_r;
    logic                  v1_r;
    logic [DAC_BITS-1:0]   pend_word_r;
    logic                  pending_r;
    logic                  overrun_r;
    logic                  clip_r;

    state_t                state_r;
    logic [DAC_BITS-2:0]   shift_r;
    logic [DW-1:0]         div_r;
    logic [BW-1:0]         bit_r;
    logic                  ldac_cnt_r;
    logic                  sclk_r;
    logic                  mosi_r;
    logic                  csn_r;
    logic                  ldacn_r;

    logic signed [31:0]    x_s;
    logic signed [PW-1:0]  xe_s;
    logic signed [PW-1:0]  ge_s;
    logic signed [PW-1:0]  p_s;
    logic signed [PW-1:0]  y_s;
    logic signed [ZW-1:0]  z_s;
    logic [DAC_BITS-1:0]   zc_s;
    logic                  sat_s;
    logic [DAC_BITS-1:0]   code_s;
    logic                  clip_evt_s;
    logic                  consume_s;
    logic                  ovr_set_s;
    logic                  clip_set_s;

    // Stage-2 datapath; widths chosen so nothing wraps before the clamp.
    always_comb begin
        x_s  = sample_r >>> SAMPLE_SHIFT;
        xe_s = {{(PW-32){x_s[31]}}, x_s};
        ge_s = {{(PW-16){1'b0}}, Gain};
        p_s  = xe_s * ge_s;
        y_s  = p_s >>> GAIN_FRAC;
        z_s  = {y_s[PW-1], y_s} + {{(ZW-16){Offset[15]}}, Offset};
        zc_s  = z_s[DAC_BITS-1:0];
        sat_s = 1'b0;
        if (z_s > Z_MAX) begin
            zc_s  = Z_MAX[DAC_BITS-1:0];
            sat_s = 1'b1;
        end else if (z_s < Z_MIN) begin
            zc_s  = Z_MIN[DAC_BITS-1:0];
            sat_s = 1'b1;
        end else begin
            zc_s  = z_s[DAC_BITS-1:0];
            sat_s = 1'b0;
        end
        code_s     = {1'b1, {(DAC_BITS-1){1'b0}}};
        clip_evt_s = 1'b0;
        if (Mute) begin
            code_s     = {1'b1, {(DAC_BITS-1){1'b0}}};
            clip_evt_s = 1'b0;
        end else begin
            code_s     = {~zc_s[DAC_BITS-1], zc_s[DAC_BITS-2:0]};
            clip_evt_s = sat_s;
        end
    end

    // A load in IDLE consumes the pending word; a write that is not consumed overruns.
    always_comb begin
        consume_s  = (state_r == ST_IDLE) && pending_r;
        ovr_set_s  = v1_r && pending_r && !consume_s;
        clip_set_s = v1_r && clip_evt_s;
    end

    // Capture, pending word and sticky flags (set wins over clear).
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            sample_r    <= 32'sd0;
            v1_r        <= 1'b0;
            pend_word_r <= '0;
            pending_r   <= 1'b0;
            overrun_r   <= 1'b0;
            clip_r      <= 1'b0;
        end else begin
            v1_r <= Enable;
            if (Enable) begin
                sample_r <= sample_in;
            end else begin
                sample_r <= sample_r;
            end
            if (v1_r) begin
                pend_word_r <= code_s;
                pending_r   <= 1'b1;
            end else if (consume_s) begin
                pending_r   <= 1'b0;
            end else begin
                pending_r   <= pending_r;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_flags) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (clip_set_s) begin
                clip_r <= 1'b1;
            end else if (clr_flags) begin
                clip_r <= 1'b0;
            end else begin
                clip_r <= clip_r;
            end
        end
    end

    // SPI frame FSM: MSB first, mosi changes only as sclk falls.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            div_r      <= '0;
            bit_r      <= '0;
            ldac_cnt_r <= 1'b0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            csn_r      <= 1'b1;
            ldacn_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_r) begin
                        shift_r <= pend_word_r[DAC_BITS-2:0];
                        mosi_r  <= pend_word_r[DAC_BITS-1];
                        csn_r   <= 1'b0;
                        sclk_r  <= 1'b0;
                        div_r   <= '0;
                        bit_r   <= '0;
                        state_r <= ST_SHIFT;
                    end else begin
                        csn_r   <= 1'b1;
                        ldacn_r <= 1'b1;
                        sclk_r  <= 1'b0;
                        mosi_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (div_r == DIV_LAST) begin
                        div_r <= '0;
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                        end else begin
                            sclk_r <= 1'b0;
                            if (bit_r == BIT_LAST) begin
                                csn_r   <= 1'b1;
                                mosi_r  <= 1'b0;
                                state_r <= ST_CSH;
                            end else begin
                                bit_r   <= bit_r + BIT_INC;
                                mosi_r  <= shift_r[DAC_BITS-2];
                                shift_r <= {shift_r[DAC_BITS-3:0], 1'b0};
                            end
                        end
                    end else begin
                        div_r <= div_r + DIV_INC;
                    end
                end
                ST_CSH: begin
                    ldacn_r    <= 1'b0;
                    ldac_cnt_r <= 1'b0;
                    state_r    <= ST_LDAC;
                end
                ST_LDAC: begin
                    if (ldac_cnt_r) begin
                        ldacn_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        ldac_cnt_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    csn_r   <= 1'b1;
                    ldacn_r <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dac_sclk  = sclk_r;
    assign dac_mosi  = mosi_r;
    assign dac_csn   = csn_r;
    assign dac_ldacn = ldacn_r;
    assign busy      = (state_r != ST_IDLE) | pending_r | v1_r;
    assign overrun   = overrun_r;
    assign clip      = clip_r;

endmodule

// File: tb/tb_dac_output_stage.sv
// Directed bench for dac_output_stage: a negedge monitor decodes SPI frames into queues,
// the main sequence compares them with hand-computed codes and timing.
module tb_dac_output_stage;

    logic        Fg_clk = 1'b0;
    logic        Resetn;
    logic        Enable;
    logic [31:0] sample_in;
    logic [15:0] Gain;
    logic [15:0] Offset;
    logic        Mute;
    logic        clr_flags;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        dac_csn;
    logic        dac_ldacn;
    logic        busy;
    logic        overrun;
    logic        clip;

    int checks   = 0;
    int failures = 0;

    logic [15:0] word_q[$];
    int          csn_q[$];
    int          bits_q[$];
    int          ldac_q[$];

    logic        prev_sclk_m = 1'b0;
    logic        in_frame_m  = 1'b0;
    int          csn_cnt_m   = 0;
    int          bits_m      = 0;
    int          ldac_cnt_m  = 0;
    logic [15:0] sh_m        = 16'h0000;

    dac_output_stage dut (
        .Fg_clk    (Fg_clk),
        .Resetn    (Resetn),
        .Enable    (Enable),
        .sample_in (sample_in),
        .Gain      (Gain),
        .Offset    (Offset),
        .Mute      (Mute),
        .clr_flags (clr_flags),
        .dac_sclk  (dac_sclk),
        .dac_mosi  (dac_mosi),
        .dac_csn   (dac_csn),
        .dac_ldacn (dac_ldacn),
        .busy      (busy),
        .overrun   (overrun),
        .clip      (clip)
    );

    always #5 Fg_clk = ~Fg_clk;

    // Frame decoder: bits are taken where sclk rises, frames close when csn rises.
    always @(negedge Fg_clk) begin
        if (!Resetn) begin
            in_frame_m  = 1'b0;
            csn_cnt_m   = 0;
            bits_m      = 0;
            ldac_cnt_m  = 0;
            prev_sclk_m = 1'b0;
        end else begin
            if (!dac_csn) begin
                if (!in_frame_m) begin
                    in_frame_m = 1'b1;
                    csn_cnt_m  = 0;
                    bits_m     = 0;
                    sh_m       = 16'h0000;
                end
                csn_cnt_m++;
                if (dac_sclk && !prev_sclk_m) begin
                    sh_m = {sh_m[14:0], dac_mosi};
                    bits_m++;
                end
            end else if (in_frame_m) begin
                in_frame_m = 1'b0;
                word_q.push_back(sh_m);
                csn_q.push_back(csn_cnt_m);
                bits_q.push_back(bits_m);
            end
            if (!dac_ldacn) begin
                ldac_cnt_m++;
            end else if (ldac_cnt_m != 0) begin
                ldac_q.push_back(ldac_cnt_m);
                ldac_cnt_m = 0;
            end
            prev_sclk_m = dac_sclk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Fg_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [31:0] s);
        Enable    = 1'b1;
        sample_in = s;
        tick();
        Enable    = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int t = 0;
        while (word_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, (word_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic frame(input logic [31:0] s, input logic [15:0] exp, input string tag);
        int nf = word_q.size();
        pulse(s);
        wait_frames(nf + 1, 150, {tag, "_done"});
        check(tag, {16'h0000, word_q[nf]}, {16'h0000, exp});
        repeat (4) tick();
    endtask

    initial begin
        int nf;
        Resetn    = 1'b0;
        Enable    = 1'b0;
        sample_in = 32'h0000_0000;
        Gain      = 16'h8000;
        Offset    = 16'h0000;
        Mute      = 1'b0;
        clr_flags = 1'b0;
        repeat (3) tick();
        check("rst_csn",   {31'd0, dac_csn},   32'd1);
        check("rst_sclk",  {31'd0, dac_sclk},  32'd0);
        check("rst_mosi",  {31'd0, dac_mosi},  32'd0);
        check("rst_ldacn", {31'd0, dac_ldacn}, 32'd1);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_ovr",   {31'd0, overrun},   32'd0);
        check("rst_clip",  {31'd0, clip},      32'd0);
        Resetn = 1'b1;
        repeat (5) tick();
        check("idle_csn",  {31'd0, dac_csn}, 32'd1);
        check("idle_busy", {31'd0, busy},    32'd0);

        // Midscale frame with exact edge-by-edge timing.
        nf = word_q.size();
        pulse(32'h0000_0000);
        check("lat_e1_csn",  {31'd0, dac_csn}, 32'd1);
        check("lat_e1_busy", {31'd0, busy},    32'd1);
        tick();
        check("lat_e2_csn", {31'd0, dac_csn}, 32'd1);
        tick();
        check("lat_e3_csn", {31'd0, dac_csn}, 32'd0);
        repeat (66) tick();
        check("ldac_low",     {31'd0, dac_ldacn}, 32'd0);
        check("ldac_csn_hi",  {31'd0, dac_csn},   32'd1);
        tick();
        check("frame_end_ldacn", {31'd0, dac_ldacn}, 32'd1);
        check("frame_end_busy",  {31'd0, busy},      32'd0);
        tick();
        check("t2_nframes", word_q.size(), nf + 1);
        check("t2_word",    {16'h0000, word_q[nf]}, 32'h0000_8000);
        check("t2_csn_len", csn_q[nf],  32'd64);
        check("t2_nbits",   bits_q[nf], 32'd16);
        check("t2_ldac_len", ldac_q[nf], 32'd2);

        // Gain and offset arithmetic.
        frame(32'h1000_0000, 16'hC000, "t3_unity");
        Gain   = 16'h4000;
        Offset = 16'h1000;
        frame(32'h1000_0000, 16'hB000, "t3_half_off");
        check("t3_clip", {31'd0, clip}, 32'd0);
        Gain   = 16'h8000;
        Offset = 16'hFF00;
        frame(32'hF000_0000, 16'h3F00, "t3_neg_off");
        check("t3_neg_clip", {31'd0, clip}, 32'd0);

        // Saturation and sticky clip.
        Offset = 16'h0000;
        frame(32'h7FFF_FFFF, 16'hFFFF, "t4_pos_sat");
        check("t4_clip_set", {31'd0, clip}, 32'd1);
        frame(32'h8000_0000, 16'h0000, "t4_neg_sat");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t4_clip_clr", {31'd0, clip}, 32'd0);
        nf = word_q.size();
        Enable    = 1'b1;
        sample_in = 32'h7FFF_FFFF;
        tick();
        Enable    = 1'b0;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t4_set_wins", {31'd0, clip}, 32'd1);
        wait_frames(nf + 1, 150, "t4_coinc_done");
        check("t4_coinc_word", {16'h0000, word_q[nf]}, 32'h0000_FFFF);
        repeat (4) tick();

        // Mute forces midscale and leaves clip alone.
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        Mute = 1'b1;
        frame(32'h7FFF_FFFF, 16'h8000, "t5_mute");
        check("t5_clip", {31'd0, clip}, 32'd0);
        Mute = 1'b0;

        // Reset in the middle of a frame.
        pulse(32'h7FFF_FFFF);
        repeat (20) tick();
        check("t1_in_frame", {31'd0, dac_csn}, 32'd0);
        check("t1_clip_pre", {31'd0, clip},    32'd1);
        nf = word_q.size();
        Resetn = 1'b0;
        #1;
        check("t1_csn",   {31'd0, dac_csn},   32'd1);
        check("t1_sclk",  {31'd0, dac_sclk},  32'd0);
        check("t1_ldacn", {31'd0, dac_ldacn}, 32'd1);
        check("t1_busy",  {31'd0, busy},      32'd0);
        check("t1_clip",  {31'd0, clip},      32'd0);
        check("t1_ovr",   {31'd0, overrun},   32'd0);
        repeat (3) tick();
        Resetn = 1'b1;
        repeat (10) tick();
        check("t1_post_csn",  {31'd0, dac_csn}, 32'd1);
        check("t1_post_busy", {31'd0, busy},    32'd0);
        check("t1_no_frame",  word_q.size(),    nf);

        // Enable every 20 cycles: frames carry samples 0, 3 and 5 of six.
        nf = word_q.size();
        for (int i = 0; i < 6; i++) begin
            pulse(32'(i + 1) << 20);
            repeat (19) tick();
        end
        wait_frames(nf + 3, 300, "t6_fast_done");
        check("t6_ovr_set", {31'd0, overrun}, 32'd1);
        check("t6_w0", {16'h0000, word_q[nf]},     32'h0000_8040);
        check("t6_w1", {16'h0000, word_q[nf + 1]}, 32'h0000_8100);
        check("t6_w2", {16'h0000, word_q[nf + 2]}, 32'h0000_8180);
        repeat (80) tick();
        check("t6_no_extra", word_q.size(), nf + 3);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t6_ovr_clr", {31'd0, overrun}, 32'd0);

        // Enable every 70 cycles: every sample goes out in order.
        nf = word_q.size();
        for (int i = 0; i < 4; i++) begin
            pulse(32'(i + 1) << 24);
            repeat (69) tick();
        end
        wait_frames(nf + 4, 150, "t6_slow_done");
        check("t6_slow_ovr", {31'd0, overrun}, 32'd0);
        check("t6_s0", {16'h0000, word_q[nf]},     32'h0000_8400);
        check("t6_s1", {16'h0000, word_q[nf + 1]}, 32'h0000_8800);
        check("t6_s2", {16'h0000, word_q[nf + 2]}, 32'h0000_8C00);
        check("t6_s3", {16'h0000, word_q[nf + 3]}, 32'h0000_9000);
        repeat (10) tick();

        // Third write lands on the edge that loads the second word: no overrun.
        nf = word_q.size();
        pulse(32'hFF00_0000);
        repeat (29) tick();
        pulse(32'h0040_0000);
        repeat (38) tick();
        pulse(32'hFFFF_C000);
        wait_frames(nf + 3, 250, "coll_done");
        check("coll_ovr", {31'd0, overrun}, 32'd0);
        check("coll_w0", {16'h0000, word_q[nf]},     32'h0000_7C00);
        check("coll_w1", {16'h0000, word_q[nf + 1]}, 32'h0000_8100);
        check("coll_w2", {16'h0000, word_q[nf + 2]}, 32'h0000_7FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
